keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad and debounces presses.
- Emits one 4-bit key code with a single-cycle strobe per physical press.
- Sits directly upstream of the two-digit history register: `s` and `en` connect straight to its `s`/`en` inputs.
- Rows come from FPGA pins with pull-ups; columns are driven by this block.

Parameters:
- SCAN_DIV, 8'd200: clock cycles each column is driven during scanning; minimum 4.
- DEBOUNCE_CYCLES, 20'd960000: cycles a press or release must stay stable (20 ms at 48 MHz).
- CNT_W, 20: width of the shared dwell/debounce counter; must hold max(SCAN_DIV, DEBOUNCE_CYCLES).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rows  input  4  keypad row lines, active-low, asynchronous to clk.
- cols  output  4  keypad column drives, active-low, exactly one low at any time.
- s  output  4  code of the last accepted key.
- en  output  1  one-cycle strobe marking a new key on `s`.

Behaviour:
- **Synchronizer:** `rows` pass through a 2-flop synchronizer, giving `rs`. All decisions use `rs` only. Synchronizer flops reset to 4'hF.
- **Reset (reset=0, async):**
  - state=SCAN, column index=0, cols=4'b1110, counter=0.
  - s=4'h0, en=0.
  - Reset asserted in any state aborts it; no en pulse is produced.
- **Key map, row r / col c:**
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
  - Codes are hex; * maps to E, # maps to F.
- **SCAN:**
  - Counter increments every cycle. At SCAN_DIV-1 it wraps to 0 and the column index advances (3 wraps to 0); cols = ~(1<<idx).
  - While counter < 3, `rs` is ignored because it may reflect the previous column.
  - When counter ≥ 3 and `rs` has exactly one zero bit: latch row index and column, clear counter, go to DEBOUNCE next cycle.
  - Zero or ≥2 zero bits: keep scanning.
- **DEBOUNCE:**
  - cols frozen; counter increments.
  - If `rs` ≠ the latched one-hot-low pattern: go to SCAN, counter=0, column index +1.
  - If counter reaches DEBOUNCE_CYCLES-1 with pattern still matching:
    - next cycle en=1 for exactly one cycle;
    - s=decoded key, updated in the same cycle as en;
    - go to HELD.
- **HELD:**
  - cols frozen.
  - Stays while the latched row bit of `rs` is 0; other row bits are ignored, so additional keys never strobe.
  - When the latched row bit reads 1: counter=0, go to RELEASE.
- **RELEASE:**
  - cols frozen; counter increments.
  - If the latched row bit reads 0: go to HELD (release bounce, no new en).
  - If counter reaches DEBOUNCE_CYCLES-1 with the bit still 1: go to SCAN, counter=0, column index +1.
- **Output holding:**
  - en is 0 in every cycle except the single accept cycle.
  - s holds its value until the next accept; a repeated press of the same key re-strobes en with unchanged s.
- **Latency:** from the first cycle `rs` shows the stable press during a valid scan window, en asserts DEBOUNCE_CYCLES+1 cycles later.
- **Counter:** never exceeds its terminal value; no wrap in DEBOUNCE or RELEASE.

Test Plan:
All tests use SCAN_DIV=8, DEBOUNCE_CYCLES=16, and a keypad model connecting a row to a column when pressed.

1. **Reset:** assert reset for 3 cycles mid-scan, then release. Required: cols=1110, s=0, en=0. Columns then step 1110→1101→1011→0111→1110, 8 cycles each.
2. **Clean press:** press '5' (r1,c1) and hold 200 cycles. Required: exactly one en pulse with s=4'h5; cols stuck at 1101 while held; no further en. Release clean for 20 cycles, then scanning resumes at 1011.
3. **Press bounce:** toggle r2 at c2 every 5 cycles for 40 cycles, then hold steady. Required: no en during chatter; one en with s=4'h9 after 17 stable cycles.
4. **Release bounce:** hold '0' until accepted (s=0). Release with 3 chatter glitches under 16 cycles, then release clean. Required: no second en; scan resumes after 16 clean-release cycles. Press '0' again: a second en with s=0.
5. **Two keys:** hold 'A' until accepted, then also press '7' for 100 cycles. Required: no en for '7' and s stays 4'hA. Release both, press '7' alone: en with s=4'h7.
6. **Reset in DEBOUNCE:** press 'D' and assert reset at debounce count 10. Required: en never pulses, s=0, cols=1110. Key still held after reset: en at the normal latency with s=4'hD.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low matrix keypad scanner with debounce and one strobe per press
module keypad_scanner #(
  parameter logic [7:0]  SCAN_DIV        = 8'd200,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd960000,
  parameter int          CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] s,
  output logic       en
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 8'd1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 20'd1);
  localparam logic [CNT_W-1:0] SETTLE    = CNT_W'(3);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state, state_n;
  logic [3:0]       rows_meta, rs;
  logic [1:0]       idx, idx_n;
  logic [1:0]       row_idx, row_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       s_n;
  logic             en_n;
  logic             hit;
  logic [1:0]       hit_row;
  logic [3:0]       row_pat;

  // Map a latched (row, column) pair to its key code.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
  endfunction

  // Only one driven column at a time; the index freezes outside SCAN.
  assign cols    = ~(4'b0001 << idx);
  assign row_pat = ~(4'b0001 << row_idx);

  // Two-flop synchronizer for the asynchronous row pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_meta <= 4'hF;
      rs        <= 4'hF;
    end else begin
      rows_meta <= rows;
      rs        <= rows_meta;
    end
  end

  // Exactly one low row bit is a candidate press; anything else is ignored.
  always_comb begin
    hit     = 1'b1;
    hit_row = 2'd0;
    case (rs)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: hit = 1'b0;
    endcase
  end

  // State, counter, latched key and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= SCAN;
      idx     <= 2'd0;
      row_idx <= 2'd0;
      cnt     <= '0;
      s       <= 4'h0;
      en      <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      row_idx <= row_n;
      cnt     <= cnt_n;
      s       <= s_n;
      en      <= en_n;
    end
  end

  // Scan / debounce / hold / release sequencing sharing one counter.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    row_n   = row_idx;
    cnt_n   = cnt;
    s_n     = s;
    en_n    = 1'b0;
    case (state)
      SCAN: begin
        // The first cycles after a column change may still show the old column.
        if (cnt >= SETTLE && hit) begin
          row_n   = hit_row;
          cnt_n   = '0;
          state_n = DEBOUNCE;
        end else if (cnt == SCAN_LAST) begin
          cnt_n = '0;
          idx_n = idx + 2'd1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      DEBOUNCE: begin
        if (rs != row_pat) begin
          state_n = SCAN;
          cnt_n   = '0;
          idx_n   = idx + 2'd1;
        end else if (cnt == DEB_LAST) begin
          en_n    = 1'b1;
          s_n     = key_code(row_idx, idx);
          state_n = HELD;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      HELD: begin
        // Other rows are ignored so a second key cannot strobe.
        if (rs[row_idx]) begin
          cnt_n   = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!rs[row_idx]) begin
          cnt_n   = '0;
          state_n = HELD;
        end else if (cnt == DEB_LAST) begin
          state_n = SCAN;
          cnt_n   = '0;
          idx_n   = idx + 2'd1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] s;
  logic       en;

  logic [15:0] pressed;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          en_count = 0;
  logic [3:0]  en_s     = 4'h0;

  // Key legend indexed by row*4+col.
  logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(
    .SCAN_DIV(8'd8),
    .DEBOUNCE_CYCLES(20'd16),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rows(rows),
    .cols(cols),
    .s(s),
    .en(en)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (en === 1'b1) begin
      en_count = en_count + 1;
      en_s     = s;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input int start, input int budget, input string tag);
    int k;
    k = 0;
    while (en_count == start && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, en_count, start + 1);
  endtask

  initial begin
    int         start;
    logic [3:0] exp_cols;
    int         key;

    reset   = 1'b0;
    pressed = '0;
    tick(3);
    reset = 1'b1;
    tick(13);

    // Reset mid-scan, then column stepping 8 cycles per column
    reset = 1'b0;
    #1;
    check("t1_rst_cols", cols, 4'b1110);
    check("t1_rst_s", s, 4'h0);
    check("t1_rst_en", en, 1'b0);
    tick(3);
    check("t1_rst_cols_hold", cols, 4'b1110);
    reset = 1'b1;
    for (int k = 0; k < 33; k++) begin
      exp_cols = ~(4'b0001 << ((k / 8) % 4));
      check("t1_step_cols", cols, exp_cols);
      check("t1_step_en", en, 1'b0);
      tick(1);
    end

    // Clean press of '5'
    start = en_count;
    pressed[1*4+1] = 1'b1;
    tick(200);
    check("t2_count", en_count, start + 1);
    check("t2_s", en_s, key_map[5]);
    check("t2_cols_held", cols, 4'b1101);
    pressed = '0;
    tick(17);
    check("t2_cols_release", cols, 4'b1101);
    tick(5);
    check("t2_cols_resume", cols, 4'b1011);
    check("t2_count_after", en_count, start + 1);

    // Press chatter on '9' then steady hold
    start = en_count;
    for (int i = 0; i < 8; i++) begin
      pressed[2*4+2] = ~pressed[2*4+2];
      tick(5);
    end
    check("t3_chatter_no_en", en_count, start);
    pressed[2*4+2] = 1'b1;
    tick(100);
    check("t3_count", en_count, start + 1);
    check("t3_s", en_s, 4'h9);
    pressed = '0;
    tick(30);

    // Release chatter on '0'
    start = en_count;
    pressed[3*4+1] = 1'b1;
    wait_en(start, 150, "t4_accept");
    check("t4_s", s, 4'h0);
    tick(5);
    for (int i = 0; i < 3; i++) begin
      pressed[3*4+1] = 1'b0;
      tick(5);
      pressed[3*4+1] = 1'b1;
      tick(3);
    end
    pressed[3*4+1] = 1'b0;
    tick(17);
    check("t4_cols_not_resumed", cols, 4'b1101);
    tick(5);
    check("t4_cols_resumed", cols, 4'b1011);
    check("t4_no_second_en", en_count, start + 1);
    start = en_count;
    pressed[3*4+1] = 1'b1;
    wait_en(start, 150, "t4_repress");
    check("t4_repress_s", en_s, 4'h0);
    pressed = '0;
    tick(30);

    // Two keys: 'A' held, '7' added
    start = en_count;
    pressed[0*4+3] = 1'b1;
    wait_en(start, 150, "t5_accept_a");
    check("t5_s_a", s, 4'hA);
    pressed[2*4+0] = 1'b1;
    tick(100);
    check("t5_no_en_7", en_count, start + 1);
    check("t5_s_still_a", s, 4'hA);
    check("t5_cols_frozen", cols, 4'b0111);
    pressed = '0;
    tick(30);
    start = en_count;
    pressed[2*4+0] = 1'b1;
    wait_en(start, 150, "t5_accept_7");
    check("t5_s_7", en_s, 4'h7);
    pressed = '0;
    tick(30);

    // Random single presses against the key legend
    for (int i = 0; i < 6; i++) begin
      key   = $urandom_range(15);
      start = en_count;
      pressed[key] = 1'b1;
      wait_en(start, 150, "rnd_accept");
      check("rnd_s", en_s, key_map[key]);
      tick($urandom_range(40, 5));
      check("rnd_single_en", en_count, start + 1);
      pressed = '0;
      tick(30);
    end

    // Reset during DEBOUNCE on 'D', then exact latency with the key still held
    reset = 1'b0;
    pressed[3*4+3] = 1'b1;
    tick(2);
    reset = 1'b1;
    start = en_count;
    tick(38);
    reset = 1'b0;
    #1;
    check("t6_rst_s", s, 4'h0);
    check("t6_rst_cols", cols, 4'b1110);
    check("t6_rst_en", en, 1'b0);
    check("t6_no_en", en_count, start);
    tick(3);
    reset = 1'b1;
    tick(43);
    check("t6_en_early", en, 1'b0);
    tick(1);
    check("t6_en_on_time", en, 1'b1);
    check("t6_s", s, 4'hD);
    tick(1);
    check("t6_en_single", en, 1'b0);
    check("t6_count", en_count, start + 1);
    pressed = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
